// File: rtl/nn_inference_sequencer_if.sv
// Host/datapath bundle for nn_inference_sequencer.
//   go, sample_in         : host request and the 62-byte sample it carries
//   dp_ready, dp_test_out : datapath all-neurons-ready flag and class result
//   dp_test_data          : held sample driven to the neurons
//   dp_start/hidden/ld1/ld2/state : per-layer datapath control
//   busy, done, class_out, error, infer_count : status back to the host
// The master modport is the environment (host + datapath); the slave modport
// is the sequencer itself.
interface nn_seq_if #(
  parameter int DATA_W = 496,
  parameter int CNT_W  = 16
);
  logic              go;
  logic [DATA_W-1:0] sample_in;
  logic              dp_ready;
  logic [7:0]        dp_test_out;
  logic [DATA_W-1:0] dp_test_data;
  logic              dp_start;
  logic              dp_hidden;
  logic              dp_ld1;
  logic              dp_ld2;
  logic [1:0]        dp_state;
  logic              busy;
  logic              done;
  logic [7:0]        class_out;
  logic              error;
  logic [CNT_W-1:0]  infer_count;

  modport master (
    output go, sample_in, dp_ready, dp_test_out,
    input  dp_test_data, dp_start, dp_hidden, dp_ld1, dp_ld2, dp_state,
           busy, done, class_out, error, infer_count
  );

  modport slave (
    input  go, sample_in, dp_ready, dp_test_out,
    output dp_test_data, dp_start, dp_hidden, dp_ld1, dp_ld2, dp_state,
           busy, done, class_out, error, infer_count
  );
endinterface

// File: rtl/nn_inference_sequencer.sv
// Control sequencer in front of the 10-neuron ANN datapath. Accepts one sample
// on go (IDLE only), holds it on dp_test_data, and walks the datapath through
// hidden layer 1, hidden layer 2 and the output layer. Each layer is a
// START (one-cycle dp_start) / WAIT (for dp_ready) / LOAD sequence; the output
// layer ends in DONE, which pulses done after class_out/infer_count update.
// Ports: clk, rst (synchronous, active-high), bus (nn_seq_if.slave).
// All control outputs are decoded from the state register only.
module nn_inference_sequencer #(
  parameter int DATA_W    = 496,
  parameter int ARM_DELAY = 2,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic    clk,
  input  logic    rst,
  nn_seq_if.slave bus
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_L1_START, S_L1_WAIT, S_L1_LOAD,
    S_L2_START, S_L2_WAIT, S_L2_LOAD,
    S_OUT_START, S_OUT_WAIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [DATA_W-1:0] sample_q;
  logic [7:0]        class_q;
  logic              error_q;
  logic [CNT_W-1:0]  count_q;

  logic in_wait, in_start, ready_ok, timed_out;
  logic accept, out_exit, tmo_hit;

  assign in_wait  = (state_q == S_L1_WAIT) || (state_q == S_L2_WAIT) ||
                    (state_q == S_OUT_WAIT);
  assign in_start = (state_q == S_L1_START) || (state_q == S_L2_START) ||
                    (state_q == S_OUT_START);
  // The first ARM_DELAY wait cycles ignore dp_ready, which may still be
  // asserted from the layer that just finished.
  assign ready_ok  = bus.dp_ready && (wait_cnt_q >= WCNT_W'(ARM_DELAY));
  assign timed_out = (wait_cnt_q == WCNT_W'(TIMEOUT - 1));

  assign accept   = (state_q == S_IDLE) && bus.go;
  assign out_exit = (state_q == S_OUT_WAIT) && ready_ok;
  // Ready wins over timeout when both occur in the same cycle.
  assign tmo_hit  = in_wait && !ready_ok && timed_out;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (bus.go) state_d = S_L1_START;
      S_L1_START:  state_d = S_L1_WAIT;
      S_L1_WAIT:   if (ready_ok) state_d = S_L1_LOAD;
                   else if (timed_out) state_d = S_IDLE;
      S_L1_LOAD:   state_d = S_L2_START;
      S_L2_START:  state_d = S_L2_WAIT;
      S_L2_WAIT:   if (ready_ok) state_d = S_L2_LOAD;
                   else if (timed_out) state_d = S_IDLE;
      S_L2_LOAD:   state_d = S_OUT_START;
      S_OUT_START: state_d = S_OUT_WAIT;
      S_OUT_WAIT:  if (ready_ok) state_d = S_DONE;
                   else if (timed_out) state_d = S_IDLE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dp_start  = in_start;
    bus.dp_ld1    = (state_q == S_L1_LOAD);
    bus.dp_ld2    = (state_q == S_L2_LOAD);
    bus.done      = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.dp_hidden = 1'b0;
    bus.dp_state  = 2'b00;
    unique case (state_q)
      S_L1_START, S_L1_WAIT, S_L1_LOAD: begin
        bus.dp_hidden = 1'b1;
        bus.dp_state  = 2'b00;
      end
      S_L2_START, S_L2_WAIT, S_L2_LOAD: begin
        bus.dp_hidden = 1'b1;
        bus.dp_state  = 2'b01;
      end
      S_OUT_START, S_OUT_WAIT, S_DONE: begin
        bus.dp_state  = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      sample_q   <= '0;
      class_q    <= '0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (in_start)
        wait_cnt_q <= '0;
      else if (in_wait)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      if (accept) begin
        sample_q <= bus.sample_in;
        error_q  <= 1'b0;
      end
      if (tmo_hit)
        error_q <= 1'b1;
      if (out_exit) begin
        class_q <= bus.dp_test_out;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.dp_test_data = sample_q;
  assign bus.class_out    = class_q;
  assign bus.error        = error_q;
  assign bus.infer_count  = count_q;

endmodule
